// File: rtl/sram_map_pkg.sv
// Text-buffer memory map shared by the SRAM arbiter, VGA char_pos and SD loader.
// The buffer holds 80x30 cells of {color[15:8], ascii[7:0]}.
package sram_map_pkg;

    localparam int          ADDR_W     = 18;
    localparam int          DATA_W     = 16;
    localparam int          CNT_W      = 12;
    localparam int          PH_W       = 3;
    localparam logic [17:0] OFFSET     = 18'h3F69F;
    localparam int          TEXT_WORDS = 2400;
    localparam int          SLOT_LEN   = 8;
    localparam logic [2:0]  PH_VGA     = 3'd0;
    localparam logic [2:0]  PH_LCD     = 3'd1;

    typedef enum logic [2:0] {
        SEL_IDLE,
        SEL_VGA,
        SEL_LCD,
        SEL_CLR,
        SEL_WR,
        SEL_OOB
    } slot_sel_e;

endpackage

// File: rtl/text_clear_engine.sv
// Screen-clear sequencer: walks cell indices 0..TEXT_WORDS-1, advancing one
// cell per grant from the arbiter, and drops busy after the last grant.
module text_clear_engine #(
    parameter int TEXT_WORDS = 2400,
    parameter int CNT_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             grant,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    import sram_map_pkg::*;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TEXT_WORDS - 1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        if (!busy_q) begin
            if (start) begin
                busy_d = 1'b1;
            end
        end else if (grant) begin
            if (count_q == LAST_IDX) begin
                busy_d  = 1'b0;
                count_d = '0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;

endmodule

// File: rtl/sram_slot_arbiter.sv
// Time-slotted arbiter for the shared text-buffer SRAM: phase 0 feeds VGA,
// phase 1 the LCD mirror, all other cycles the clear engine and write port.
module sram_slot_arbiter #(
    parameter int                ADDR_W     = 18,
    parameter int                DATA_W     = 16,
    parameter logic [ADDR_W-1:0] OFFSET     = sram_map_pkg::OFFSET,
    parameter int                TEXT_WORDS = sram_map_pkg::TEXT_WORDS
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              char_tick,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              lcd_req,
    input  logic [4:0]        lcd_idx,
    output logic [7:0]        lcd_data,
    output logic              lcd_ack,
    input  logic              wr_req,
    input  logic [11:0]       wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_oob,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);
    import sram_map_pkg::*;

    localparam logic [11:0] WORDS = 12'(TEXT_WORDS);

    logic [PH_W-1:0]   ph_q, ph_d, eff_ph;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic              sram_we_q, sram_we_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic              rd_vga_q, rd_vga_d;
    logic              rd_lcd_q, rd_lcd_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_valid_q, vga_valid_d;
    logic [7:0]        lcd_data_q, lcd_data_d;
    logic              lcd_ack_q, lcd_ack_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_oob_q, wr_oob_d;
    logic              clr_grant;
    logic [CNT_W-1:0]  clr_count;
    slot_sel_e         sel;

    text_clear_engine #(
        .TEXT_WORDS(TEXT_WORDS),
        .CNT_W     (CNT_W)
    ) u_clear (
        .clk  (CLOCK_50),
        .rst  (reset),
        .start(clr_start),
        .grant(clr_grant),
        .busy (clr_busy),
        .count(clr_count)
    );

    assign eff_ph = char_tick ? PH_VGA : ph_q;
    assign ph_d   = eff_ph + 1'b1;

    // The ack cycle still shows the consumed request, so it is not re-served.
    always_comb begin
        sel = SEL_IDLE;
        if (eff_ph == PH_VGA) begin
            sel = SEL_VGA;
        end else if (eff_ph == PH_LCD && lcd_req && !lcd_ack_q) begin
            sel = SEL_LCD;
        end else if (clr_busy) begin
            sel = SEL_CLR;
        end else if (wr_req && !clr_start && !wr_ack_q) begin
            sel = (wr_idx >= WORDS) ? SEL_OOB : SEL_WR;
        end
    end

    always_comb begin
        sram_addr_d  = sram_addr_q;
        sram_we_d    = 1'b0;
        sram_wdata_d = sram_wdata_q;
        rd_vga_d     = 1'b0;
        rd_lcd_d     = 1'b0;
        wr_ack_d     = 1'b0;
        wr_oob_d     = 1'b0;
        clr_grant    = 1'b0;
        unique case (sel)
            SEL_VGA: begin
                sram_addr_d = vga_addr;
                rd_vga_d    = 1'b1;
            end
            SEL_LCD: begin
                sram_addr_d = OFFSET + ADDR_W'(lcd_idx);
                rd_lcd_d    = 1'b1;
            end
            SEL_CLR: begin
                sram_addr_d  = OFFSET + ADDR_W'(clr_count);
                sram_we_d    = 1'b1;
                sram_wdata_d = '0;
                clr_grant    = 1'b1;
            end
            SEL_WR: begin
                sram_addr_d  = OFFSET + ADDR_W'(wr_idx);
                sram_we_d    = 1'b1;
                sram_wdata_d = wr_data;
                wr_ack_d     = 1'b1;
            end
            SEL_OOB: begin
                wr_ack_d = 1'b1;
                wr_oob_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Reads issued on the previous edge are sampled from the DQ bus now.
    always_comb begin
        vga_data_d  = rd_vga_q ? sram_rdata : vga_data_q;
        vga_valid_d = rd_vga_q;
        lcd_data_d  = rd_lcd_q ? sram_rdata[7:0] : lcd_data_q;
        lcd_ack_d   = rd_lcd_q;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ph_q         <= '0;
            sram_addr_q  <= OFFSET;
            sram_we_q    <= 1'b0;
            sram_wdata_q <= '0;
            rd_vga_q     <= 1'b0;
            rd_lcd_q     <= 1'b0;
            vga_data_q   <= '0;
            vga_valid_q  <= 1'b0;
            lcd_data_q   <= '0;
            lcd_ack_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            wr_oob_q     <= 1'b0;
        end else begin
            ph_q         <= ph_d;
            sram_addr_q  <= sram_addr_d;
            sram_we_q    <= sram_we_d;
            sram_wdata_q <= sram_wdata_d;
            rd_vga_q     <= rd_vga_d;
            rd_lcd_q     <= rd_lcd_d;
            vga_data_q   <= vga_data_d;
            vga_valid_q  <= vga_valid_d;
            lcd_data_q   <= lcd_data_d;
            lcd_ack_q    <= lcd_ack_d;
            wr_ack_q     <= wr_ack_d;
            wr_oob_q     <= wr_oob_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_we    = sram_we_q;
    assign sram_wdata = sram_wdata_q;
    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign lcd_data   = lcd_data_q;
    assign lcd_ack    = lcd_ack_q;
    assign wr_ack     = wr_ack_q;
    assign wr_oob     = wr_oob_q;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Directed bench for sram_slot_arbiter with a behavioural async SRAM that
// covers the text buffer window starting at OFFSET.
module tb_sram_slot_arbiter;

    localparam logic [17:0] OFF = 18'h3F69F;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        char_tick = 1'b0;
    logic [17:0] vga_addr = 18'h3F6A0;
    logic [15:0] vga_data;
    logic        vga_valid;
    logic        lcd_req = 1'b0;
    logic [4:0]  lcd_idx = 5'd0;
    logic [7:0]  lcd_data;
    logic        lcd_ack;
    logic        wr_req = 1'b0;
    logic [11:0] wr_idx = 12'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_ack;
    logic        wr_oob;
    logic        clr_start = 1'b0;
    logic        clr_busy;
    logic [17:0] sram_addr;
    logic        sram_we;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    logic [15:0] mem [0:4095];
    logic [17:0] mdiff;
    logic [11:0] midx;

    int n_tests = 0;
    int n_fail  = 0;

    sram_slot_arbiter dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .char_tick (char_tick),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .lcd_req   (lcd_req),
        .lcd_idx   (lcd_idx),
        .lcd_data  (lcd_data),
        .lcd_ack   (lcd_ack),
        .wr_req    (wr_req),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .wr_oob    (wr_oob),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign mdiff      = sram_addr - OFF;
    assign midx       = mdiff[11:0];
    assign sram_rdata = mem[midx];

    always @(posedge CLOCK_50) begin
        if (sram_we) mem[midx] <= sram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Leaves the bench in a cycle whose slot phase is p.
    task automatic goto_phase(input int p);
        char_tick = 1'b1;
        cyc();
        char_tick = 1'b0;
        repeat ((p + 7) % 8) cyc();
    endtask

    initial begin
        int issue_n;
        int nw, nv, bad_w, bad_gap, early, last_v, idles, resets_we;
        bit acked;

        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[1] = 16'hFF41;
        mem[5] = 16'h1C62;

        cyc();
        cyc();
        check("rst_addr",  32'(sram_addr), 32'h3F69F);
        check("rst_we",    32'(sram_we), 0);
        check("rst_wdata", 32'(sram_wdata), 0);
        check("rst_busy",  32'(clr_busy), 0);
        check("rst_vvld",  32'(vga_valid), 0);
        reset = 1'b0;

        // VGA fetch: tick at cycle 0, data two edges later.
        char_tick = 1'b1;
        vga_addr  = 18'h3F6A0;
        cyc();
        char_tick = 1'b0;
        check("vga_addr", 32'(sram_addr), 32'h3F6A0);
        check("vga_we",   32'(sram_we), 0);
        cyc();
        check("vga_valid", 32'(vga_valid), 1);
        check("vga_data",  32'(vga_data), 32'hFF41);
        check("vga_we2",   32'(sram_we), 0);
        cyc();
        check("vga_pulse", 32'(vga_valid), 0);

        // LCD request raised in phase 3 waits for the next phase 1.
        goto_phase(3);
        lcd_idx = 5'd5;
        lcd_req = 1'b1;
        issue_n = 0;
        for (int n = 1; n <= 20 && issue_n == 0; n++) begin
            cyc();
            if (sram_addr == 18'h3F6A4) issue_n = n;
        end
        check("lcd_wait", 32'(issue_n), 7);
        check("lcd_ack0", 32'(lcd_ack), 0);
        cyc();
        check("lcd_ack",  32'(lcd_ack), 1);
        check("lcd_data", 32'(lcd_data), 32'h62);
        lcd_req = 1'b0;
        cyc();
        check("lcd_pulse", 32'(lcd_ack), 0);

        // Write raised in phase 0 goes out in the first general slot.
        goto_phase(0);
        wr_idx  = 12'h010;
        wr_data = 16'hFF5A;
        wr_req  = 1'b1;
        cyc();
        check("wr_ph0_ack", 32'(wr_ack), 0);
        check("wr_ph0_we",  32'(sram_we), 0);
        check("wr_ph0_adr", 32'(sram_addr), 32'h3F6A0);
        cyc();
        check("wr_ack",   32'(wr_ack), 1);
        check("wr_we",    32'(sram_we), 1);
        check("wr_addr",  32'(sram_addr), 32'h3F6AF);
        check("wr_wdata", 32'(sram_wdata), 32'hFF5A);
        check("wr_oob0",  32'(wr_oob), 0);
        wr_req = 1'b0;
        cyc();
        check("wr_we_off", 32'(sram_we), 0);
        check("wr_pulse",  32'(wr_ack), 0);
        check("wr_mem",    32'(mem[16]), 32'hFF5A);

        // Out-of-range index: ack with oob, no SRAM write.
        wr_idx  = 12'd2400;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        cyc();
        check("oob_ack",  32'(wr_ack), 1);
        check("oob_flag", 32'(wr_oob), 1);
        check("oob_we",   32'(sram_we), 0);
        check("oob_addr", 32'(sram_addr), 32'h3F6AF);
        wr_req = 1'b0;
        cyc();
        check("oob_pulse", 32'(wr_oob), 0);

        // Clear started alongside a pending write.
        goto_phase(3);
        vga_addr  = 18'h3F000;
        clr_start = 1'b1;
        wr_idx    = 12'd3;
        wr_data   = 16'hABCD;
        wr_req    = 1'b1;
        cyc();
        clr_start = 1'b0;
        check("clr_busy_set", 32'(clr_busy), 1);
        check("clr_wr_wait",  32'(wr_ack), 0);
        check("clr_we_first", 32'(sram_we), 0);
        nw = 0; nv = 0; bad_w = 0; bad_gap = 0; early = 0; idles = 0;
        last_v = -1;
        acked = 1'b0;
        for (int c = 0; c < 3300 && !acked; c++) begin
            cyc();
            if (wr_ack) begin
                acked = 1'b1;
                check("clr_ack_busy", 32'(clr_busy), 0);
                check("clr_ack_addr", 32'(sram_addr), 32'h3F6A2);
                check("clr_ack_we",   32'(sram_we), 1);
                check("clr_ack_data", 32'(sram_wdata), 32'hABCD);
            end else if (sram_we) begin
                if (sram_wdata != 16'h0 || sram_addr != OFF + 18'(nw))
                    bad_w++;
                nw++;
                if (nw == 2400) check("clr_busy_fall", 32'(clr_busy), 0);
                else if (!clr_busy) early++;
            end else if (sram_addr == 18'h3F000) begin
                if (last_v >= 0 && c - last_v != 8) bad_gap++;
                last_v = c;
                nv++;
            end else begin
                idles++;
            end
        end
        check("clr_acked",   32'(acked), 1);
        check("clr_count",   32'(nw), 2400);
        check("clr_wdata",   32'(bad_w), 0);
        check("clr_vga_gap", 32'(bad_gap), 0);
        check("clr_early",   32'(early), 0);
        check("clr_idle",    32'(idles), 0);
        check("clr_vga_n",   32'(nv >= 300), 1);
        wr_req = 1'b0;
        cyc();
        check("clr_mem_wr",   32'(mem[3]), 32'hABCD);
        check("clr_mem_last", 32'(mem[2399]), 0);
        check("clr_mem_lcd",  32'(mem[5]), 0);

        // char_tick mid-slot resyncs without losing or duplicating acks.
        goto_phase(4);
        wr_idx  = 12'd7;
        wr_data = 16'h5555;
        wr_req  = 1'b1;
        cyc();
        check("rs_ack1",  32'(wr_ack), 1);
        check("rs_addr1", 32'(sram_addr), 32'h3F6A6);
        wr_req    = 1'b0;
        char_tick = 1'b1;
        vga_addr  = 18'h3F6A0;
        cyc();
        char_tick = 1'b0;
        check("rs_vga_addr", 32'(sram_addr), 32'h3F6A0);
        check("rs_vga_we",   32'(sram_we), 0);
        check("rs_no_dup",   32'(wr_ack), 0);
        wr_idx  = 12'd8;
        wr_data = 16'h6666;
        wr_req  = 1'b1;
        cyc();
        check("rs_ack2",  32'(wr_ack), 1);
        check("rs_addr2", 32'(sram_addr), 32'h3F6A7);
        check("rs_vvld",  32'(vga_valid), 1);
        wr_req   = 1'b0;
        vga_addr = 18'h3F6B0;
        repeat (6) cyc();
        check("rs_ph7_hold", 32'(sram_addr), 32'h3F6A7);
        cyc();
        check("rs_ph0_vga", 32'(sram_addr), 32'h3F6B0);

        // Asynchronous reset in the middle of a clear.
        goto_phase(3);
        clr_start = 1'b1;
        cyc();
        clr_start = 1'b0;
        wr_idx  = 12'd2;
        wr_data = 16'h7777;
        wr_req  = 1'b1;
        repeat (5) cyc();
        check("mr_busy_pre", 32'(clr_busy), 1);
        #5;
        reset = 1'b1;
        #1;
        check("mr_addr",  32'(sram_addr), 32'h3F69F);
        check("mr_we",    32'(sram_we), 0);
        check("mr_wdata", 32'(sram_wdata), 0);
        check("mr_busy",  32'(clr_busy), 0);
        check("mr_ack",   32'(wr_ack), 0);
        check("mr_oob",   32'(wr_oob), 0);
        check("mr_vdata", 32'(vga_data), 0);
        check("mr_vvld",  32'(vga_valid), 0);
        check("mr_ldata", 32'(lcd_data), 0);
        check("mr_lack",  32'(lcd_ack), 0);
        wr_req = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        resets_we = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (sram_we || clr_busy || wr_ack || lcd_ack) resets_we++;
        end
        check("mr_quiet", 32'(resets_we), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
